// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared constants and types for the instruction fetch stage.
//            Holds the default datapath width and reset PC, the RISC-V
//            register-field positions, the NOP encoding and the fetch FSM
//            state type.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

   localparam int          XLEN     = 32;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   // Register-specifier positions inside a 32-bit instruction word
   localparam int RS1_LSB = 15;
   localparam int RS2_LSB = 20;
   localparam int RD_LSB  = 7;
   localparam int REG_W   = 5;

   localparam logic [31:0] NOP = 32'h0000_0013;   // addi x0,x0,0

   typedef enum logic [0:0] {
      BOOT = 1'b0,
      RUN  = 1'b1
   } fetch_state_e;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Purpose  : Small synchronous in-order FIFO with flush. Used both as the
//            instruction buffer ({pc, instr}) and as the side queue of
//            requested PCs.
// Ports    : clk, rst_n      - clock, async active-low reset
//            flush_i         - discard all entries (wins over push/pop)
//            push_i/data_i   - write an entry
//            pop_i           - remove the head entry
//            head_o          - head entry, zero when empty
//            valid_o         - FIFO not empty
//            count_o         - number of stored entries
// Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_o,
   output logic             valid_o,
   output logic [AW:0]      count_o
);

   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q;
   logic             wr_en, rd_en;

   // A push into a full FIFO is still accepted when the head leaves this cycle
   assign rd_en   = pop_i && (count_q != '0);
   assign wr_en   = push_i && ((count_q != FULL_CNT) || rd_en);

   assign valid_o = (count_q != '0);
   assign count_o = count_q;
   assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_q + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, rd_en};
      end
   end

   // Storage needs no reset: the head is masked while the FIFO is empty
   always_ff @(posedge clk) begin
      if (wr_en && !flush_i) mem_q[wr_ptr_q] <= data_i;
   end

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_unit
// Purpose  : Fetch stage. Holds the PC, issues word requests to instruction
//            memory under a credit rule that guarantees every response has a
//            buffer slot, buffers responses in order and presents one decoded
//            instruction per cycle. A redirect flushes buffered instructions
//            and drops every response still in flight.
// Ports    : clk, rst_n                 - clock, async active-low reset
//            imem_req/addr/gnt          - fetch request handshake
//            imem_rvalid/rdata          - in-order fetch responses
//            redirect_valid/pc          - taken branch/jump
//            instr_valid/ready          - downstream handshake
//            instr, instr_pc            - head instruction and its PC
//            rs1_addr, rs2_addr, rd_addr- register fields of instr
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit
   import fetch_pkg::*;
#(
   parameter int              XLEN       = fetch_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_PC   = fetch_pkg::RESET_PC,
   parameter int              FIFO_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            instr_ready,
   output logic            instr_valid,
   output logic [XLEN-1:0] instr,
   output logic [XLEN-1:0] instr_pc,
   output logic [4:0]      rs1_addr,
   output logic [4:0]      rs2_addr,
   output logic [4:0]      rd_addr
);

   localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW:0] CREDITS   = (CW + 1)'(FIFO_DEPTH);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [CW-1:0]   drop_q, drop_d;

   logic [CW-1:0]     fifo_count, pcq_count, outstanding;
   logic [2*XLEN-1:0] fifo_head;
   logic [XLEN-1:0]   pcq_head;
   logic              pcq_valid;
   logic              issue, resp, resp_keep;
   logic              has_credit;

   // Outstanding requests are either waiting to be dropped or have their PC
   // parked in the side queue, so the count is derived rather than stored.
   assign outstanding = drop_q + pcq_count;

   assign has_credit = ({1'b0, outstanding} + {1'b0, fifo_count}) < CREDITS;
   assign imem_req   = (state_q == RUN) && has_credit && !redirect_valid;
   assign imem_addr  = pc_q;

   assign issue     = imem_req && imem_gnt;
   assign resp      = imem_rvalid && (outstanding != '0);
   assign resp_keep = resp && (drop_q == '0) && pcq_valid;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      drop_d  = drop_q;

      case (state_q)
         BOOT:    state_d = RUN;
         RUN:     state_d = RUN;
         default: state_d = BOOT;
      endcase

      if (redirect_valid) begin
         pc_d   = {redirect_pc[XLEN-1:2], 2'b00};
         // Everything still in flight after this cycle's response is stale
         drop_d = outstanding - {{(CW-1){1'b0}}, resp};
      end else begin
         if (issue) pc_d = pc_q + XLEN'(4);
         if (resp && (drop_q != '0)) drop_d = drop_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= BOOT;
         pc_q    <= RESET_PC;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         drop_q  <= drop_d;
      end
   end

   // PCs of issued, not-yet-dropped requests, matched to responses in order
   fetch_fifo #(
      .WIDTH (XLEN),
      .DEPTH (FIFO_DEPTH)
   ) u_pc_queue (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (redirect_valid),
      .push_i  (issue),
      .data_i  (pc_q),
      .pop_i   (resp_keep),
      .head_o  (pcq_head),
      .valid_o (pcq_valid),
      .count_o (pcq_count)
   );

   // Instruction buffer; a redirect flush takes priority over push and pop
   fetch_fifo #(
      .WIDTH (2 * XLEN),
      .DEPTH (FIFO_DEPTH)
   ) u_instr_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (redirect_valid),
      .push_i  (resp_keep && !redirect_valid),
      .data_i  ({pcq_head, imem_rdata}),
      .pop_i   (instr_valid && instr_ready && !redirect_valid),
      .head_o  (fifo_head),
      .valid_o (instr_valid),
      .count_o (fifo_count)
   );

   // Head is already zero when the buffer is empty
   assign instr    = fifo_head[XLEN-1:0];
   assign instr_pc = fifo_head[2*XLEN-1:XLEN];
   assign rs1_addr = instr[RS1_LSB +: REG_W];
   assign rs2_addr = instr[RS2_LSB +: REG_W];
   assign rd_addr  = instr[RD_LSB  +: REG_W];

endmodule : instruction_fetch_unit
`default_nettype wire
